// File: rtl/axis_result_fifo.sv
// axis_result_fifo: first-word fall-through FIFO that buffers the FIR engine's AXI-Stream
// output (tdata + tlast) so the Wishbone read path can drain at its own pace. It also
// reports occupancy and counts frames as they are drained.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   clr_i                       synchronous flush (wins over push/pop)
//   s_tvalid/s_tdata/s_tlast    slave side from the FIR, s_tready back to the FIR
//   m_tvalid/m_tdata/m_tlast    master side head-of-queue, m_tready from the consumer
//   level/empty/full/almost_full occupancy status
//   frame_cnt                   saturating count of frames drained (pops with tlast)
//   frame_done                  one-cycle pulse the cycle after a tlast beat is popped
module axis_result_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        clr_i,
    input  logic                        s_tvalid,
    input  logic [DATA_WIDTH-1:0]       s_tdata,
    input  logic                        s_tlast,
    output logic                        s_tready,
    output logic                        m_tvalid,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [15:0]                 frame_cnt,
    output logic                        frame_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Each entry holds {tlast, tdata}; the array is deliberately not reset.
    logic [DATA_WIDTH:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          frame_done_q, frame_done_d;

    logic push, pop;

    // Status derives only from the registered level, so s_tready has no path from m_tready.
    always_comb begin
        empty       = (level_q == '0);
        full        = (level_q == LW'(DEPTH));
        almost_full = (level_q >= LW'(AFULL_THRESH));
        s_tready    = !full;
        m_tvalid    = !empty;
        {m_tlast, m_tdata} = mem_q[rd_ptr_q];
        level       = level_q;
        frame_cnt   = frame_cnt_q;
        frame_done  = frame_done_q;
    end

    // A flush swallows any handshake offered in the same cycle.
    assign push = s_tvalid && s_tready && !clr_i;
    assign pop  = m_tvalid && m_tready && !clr_i;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        if (clr_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            frame_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (m_tlast) begin
                    frame_done_d = 1'b1;
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

endmodule

// File: doc/axis_result_fifo.md
Name: axis_result_fifo

Overview:
- Buffering stage directly downstream of the FIR engine's AXI-Stream master port (sm_*).
- Stores filtered samples together with their tlast flag, so the Wishbone read path can drain them at its own pace without stalling the FIR.
- Exposes occupancy/status, a completed-frame counter and a frame-done pulse that the top level can route to irq or to a status register.

Parameters:
- DATA_WIDTH, 32, width of tdata.
- DEPTH, 16, number of entries; power of two, at least 2.
- AFULL_THRESH, 12, almost_full asserts when level >= this value; range 1..DEPTH.

Ports:
- wb_clk_i  input  1  single clock for the whole block.
- wb_rst_i  input  1  asynchronous active-high reset.
- clr_i  input  1  synchronous flush, one cycle pulse.
- s_tvalid  input  1  from FIR sm_tvalid.
- s_tdata  input  DATA_WIDTH  from FIR sm_tdata (signed sample, stored unmodified).
- s_tlast  input  1  from FIR sm_tlast.
- s_tready  output  1  to FIR sm_tready.
- m_tvalid  output  1  to Wishbone read path.
- m_tdata  output  DATA_WIDTH  head-of-queue sample.
- m_tlast  output  1  tlast of head entry.
- m_tready  input  1  consumer accepts head.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- almost_full  output  1  level >= AFULL_THRESH.
- frame_cnt  output  16  frames fully drained on m side.
- frame_done  output  1  one-cycle pulse per drained frame.

Behaviour:
- Reset (async, wb_rst_i=1): wr_ptr=rd_ptr=0, level=0, frame_cnt=0, frame_done=0.
  - Outputs during reset: s_tready=1, m_tvalid=0, empty=1, full=0, almost_full=0.
  - m_tdata and m_tlast are don't-care during reset; storage array is not reset.
- Storage: DEPTH entries of {tlast, tdata}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is a separate registered counter.
- Push: when s_tvalid && s_tready on edge N, the entry is written at wr_ptr and wr_ptr+1.
- Pop: when m_tvalid && m_tready on edge N, rd_ptr+1.
- Handshake rules:
  - s_tready = !full, taken combinationally from the registered level.
  - A push is refused when full even if a pop occurs in the same cycle. This deliberately keeps s_tready free of any path from m_tready.
  - m_tvalid = !empty.
  - m_tdata and m_tlast = mem[rd_ptr], read combinationally (first-word fall-through).
  - Once m_tvalid=1 it stays 1 and m_tdata stays stable until a pop.
- Latency: a sample pushed on edge N is visible on m_tvalid/m_tdata after edge N; one cycle of write-to-read latency when empty.
- Level update:
  - push only: +1.
  - pop only: -1.
  - simultaneous push and pop (possible only when 0<level<DEPTH): unchanged, both pointers advance.
  - push into empty with m_tready=1 the same cycle: no pop, because m_tvalid is 0 that cycle.
- Frame tracking:
  - On a pop with m_tlast=1, frame_done=1 for the next cycle only (registered).
  - On the same pop, frame_cnt increments and saturates at 16'hFFFF.
- clr_i (synchronous, wins over push/pop in the same cycle):
  - Pointers and level go to 0; frame_cnt goes to 0; frame_done goes to 0.
  - Any beat offered that cycle is dropped; no handshake is counted for it.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight data is lost.
- tlast is not required on any particular beat; frames of any length, including length 1, are counted.

Test Plan:
- Reset, then push 0x1,0x2,0x3 with m_tready=0 -> level=3, m_tdata=0x1, empty=0; then m_tready=1 for 3 cycles -> pops 0x1,0x2,0x3 in order, empty=1.
- Push 16 beats with m_tready=0 (DEPTH=16) -> full=1, s_tready=0 after 16th; almost_full=1 from level 12; 17th beat (s_tvalid held) is not accepted until one pop, then it is accepted on the following cycle.
- Steady streaming with s_tvalid=m_tready=1 over 40 beats (pointer wrap) -> level constant at 1 after first cycle; output sequence identical to input sequence, including values 0x80000000 and 0xFFFFFFFF.
- Send frame of 11 beats with tlast on 11th (values 0..10), drain -> frame_done pulses exactly one cycle after popping beat 10; frame_cnt=1; second frame -> frame_cnt=2.
- With level=5, assert clr_i together with s_tvalid=1 and m_tready=1 -> next cycle level=0, empty=1, frame_cnt=0, no output beat consumed.
- Assert wb_rst_i asynchronously mid-stream (level=7, frame_cnt=3) -> outputs return to reset values before the next clock edge; after release, a new push round-trips correctly.
